// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (double dabble, one bit per clock).
// A request is accepted in IDLE, converted in exactly W SHIFT cycles, and
// announced by a one-cycle oVALID pulse from DONE. Results hold until the
// next DONE. In two's-complement mode the magnitude is converted and the
// sign is reported separately on oNEG.
module bin2bcd_seq #(
  parameter int W      = 8,
  parameter int ND     = 3,
  parameter int SIGNED = 0
) (
  input  logic            iCLK,
  input  logic            iRST,
  input  logic            iVALID,
  input  logic [W-1:0]    iBIN,
  output logic            oREADY,
  output logic            oVALID,
  output logic [4*ND-1:0] oBCD,
  output logic            oNEG,
  output logic            oOVF
);

  localparam int BW = 4 * ND;
  localparam int CW = $clog2(W + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t          state_q;
  logic [W-1:0]    sr_q;
  logic [BW-1:0]   scr_q;
  logic            ovf_q;
  logic            neg_q;
  logic [CW-1:0]   cnt_q;

  logic [BW-1:0]   bcd_q;
  logic            valid_q;
  logic            bcd_neg_q;
  logic            bcd_ovf_q;

  logic [BW-1:0]   adj;
  logic [W-1:0]    sr_d;
  logic [BW-1:0]   scr_d;
  logic            ovf_d;
  logic            in_neg;
  logic [W-1:0]    in_mag;
  logic            last_iter;

  // Add 3 to every BCD digit that is 5 or more, all digits in parallel.
  function automatic logic [BW-1:0] dabble_adjust(input logic [BW-1:0] s);
    logic [BW-1:0] r;
    r = s;
    for (int k = 0; k < ND; k++) begin
      if (s[4*k +: 4] >= 4'd5) begin
        r[4*k +: 4] = s[4*k +: 4] + 4'd3;
      end
    end
    return r;
  endfunction

  // W-bit magnitude; the most negative input wraps to 2^(W-1) as unsigned.
  function automatic logic [W-1:0] magnitude(input logic [W-1:0] b, input logic neg);
    return neg ? ((~b) + W'(1)) : b;
  endfunction

  // One double-dabble iteration plus operand decode for the accept edge.
  always_comb begin
    adj       = dabble_adjust(scr_q);
    scr_d     = {adj[BW-2:0], sr_q[W-1]};
    sr_d      = {sr_q[W-2:0], 1'b0};
    // Whatever falls off the top of the scratch is lost precision: sticky.
    ovf_d     = ovf_q | adj[BW-1];
    last_iter = (cnt_q == CW'(W - 1));
    in_neg    = (SIGNED != 0) && iBIN[W-1];
    in_mag    = magnitude(iBIN, in_neg);
  end

  // Control FSM with the shift datapath and registered result outputs.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state_q   <= IDLE;
      sr_q      <= '0;
      scr_q     <= '0;
      ovf_q     <= 1'b0;
      neg_q     <= 1'b0;
      cnt_q     <= '0;
      bcd_q     <= '0;
      valid_q   <= 1'b0;
      bcd_neg_q <= 1'b0;
      bcd_ovf_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          valid_q <= 1'b0;
          if (iVALID) begin
            sr_q    <= in_mag;
            scr_q   <= '0;
            ovf_q   <= 1'b0;
            neg_q   <= in_neg;
            cnt_q   <= '0;
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          sr_q  <= sr_d;
          scr_q <= scr_d;
          ovf_q <= ovf_d;
          cnt_q <= cnt_q + CW'(1);
          if (last_iter) begin
            bcd_q     <= scr_d;
            bcd_neg_q <= neg_q;
            bcd_ovf_q <= ovf_d;
            valid_q   <= 1'b1;
            state_q   <= DONE;
          end
        end
        DONE: begin
          valid_q <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          valid_q <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign oREADY = (state_q == IDLE);
  assign oVALID = valid_q;
  assign oBCD   = bcd_q;
  assign oNEG   = bcd_neg_q;
  assign oOVF   = bcd_ovf_q;

endmodule
